// File: rtl/ascon_inv_unit_pkg.sv
// ascon_inv_unit_pkg: op encoding, rotation constants and decode helpers shared by the Ascon inverse unit.
package ascon_inv_unit_pkg;

    typedef enum logic [3:0] {
        ASCINV0H, ASCINV0L,
        ASCINV1H, ASCINV1L,
        ASCINV2H, ASCINV2L,
        ASCINV3H, ASCINV3L,
        ASCINV4H, ASCINV4L
    } ascon_inv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } ascon_inv_state_t;

    localparam int unsigned NUM_STAGES = 6;

    localparam logic [5:0] ASCON_ROT_A [5] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] ASCON_ROT_B [5] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

    function automatic logic [2:0] ascon_inv_sigma_idx(ascon_inv_op_t op);
        return op[3:1];
    endfunction

    function automatic logic ascon_inv_is_high(ascon_inv_op_t op);
        return ~op[0];
    endfunction

    function automatic logic ascon_inv_op_valid(ascon_inv_op_t op);
        return op <= ASCINV4L;
    endfunction

    // Doubling the word makes a zero rotate amount fall out naturally.
    function automatic logic [63:0] ascon_rotr(logic [63:0] x, logic [5:0] r);
        logic [127:0] xx;
        xx = {x, x} >> r;
        return xx[63:0];
    endfunction

endpackage

// File: rtl/ascon_inv_unit_if.sv
// ascon_inv_unit_if: request/result bundle between the EX stage (master) and the inverse unit (slave).
interface ascon_inv_unit_if;
    import ascon_inv_unit_pkg::*;

    logic          ascon_inv_en_i;
    ascon_inv_op_t ascon_inv_op_i;
    logic [31:0]   op_a_i;
    logic [31:0]   op_b_i;
    logic          flush_i;
    logic [31:0]   ascon_inv_result_o;
    logic          ascon_inv_valid_o;
    logic          ascon_inv_busy_o;

    modport master (
        output ascon_inv_en_i, ascon_inv_op_i, op_a_i, op_b_i, flush_i,
        input  ascon_inv_result_o, ascon_inv_valid_o, ascon_inv_busy_o
    );

    modport slave (
        input  ascon_inv_en_i, ascon_inv_op_i, op_a_i, op_b_i, flush_i,
        output ascon_inv_result_o, ascon_inv_valid_o, ascon_inv_busy_o
    );

endinterface

// File: rtl/ascon_inv_unit_stage.sv
// ascon_inv_stage: one combinational Sigma^(2^k) stage, x ^ rotr(x, a<<k) ^ rotr(x, b<<k) with 6-bit wrapped amounts.
module ascon_inv_stage
    import ascon_inv_unit_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  sig_i,
    input  logic [2:0]  k_i,
    output logic [63:0] data_o
);

    logic [2:0] sel;
    logic [5:0] rot_a;
    logic [5:0] rot_b;

    always_comb begin
        sel    = sig_i > 3'd4 ? 3'd0 : sig_i;
        rot_a  = ASCON_ROT_A[sel] << k_i;
        rot_b  = ASCON_ROT_B[sel] << k_i;
        data_o = data_i ^ ascon_rotr(data_i, rot_a) ^ ascon_rotr(data_i, rot_b);
    end

endmodule

// File: rtl/ascon_inv_unit.sv
// ascon_inv_unit: multi-cycle inverse of the Ascon sigma layer, computed as Sigma^63 = prod Sigma^(2^k), k=0..5.
// Multdiv-style handshake with flush abort and an optional single-entry result cache for the paired H/L op.
module ascon_inv_unit
    import ascon_inv_unit_pkg::*;
#(
    parameter bit          LOGIC_GATING     = 1'b1,
    parameter int unsigned STAGES_PER_CYCLE = 1,
    parameter bit          RESULT_CACHE     = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ascon_inv_unit_if.slave  bus
);

    if (!(STAGES_PER_CYCLE == 1 || STAGES_PER_CYCLE == 2 ||
          STAGES_PER_CYCLE == 3 || STAGES_PER_CYCLE == 6)) begin : g_bad_spc
        $error("ascon_inv_unit: STAGES_PER_CYCLE must be 1, 2, 3 or 6");
    end

    localparam logic [2:0] STEP = 3'(STAGES_PER_CYCLE);
    localparam logic [2:0] LAST = 3'(NUM_STAGES);

    ascon_inv_state_t state_q;
    logic [63:0]      data_q;
    logic [63:0]      opnd_q;
    logic [2:0]       sig_q;
    logic [2:0]       k_q;
    logic             hi_q;
    logic             bad_q;
    logic             cache_vld_q;
    logic [63:0]      cache_opnd_q;
    logic [2:0]       cache_sig_q;
    logic [63:0]      cache_res_q;

    logic [63:0] opnd;
    logic [2:0]  req_sig;
    logic        req_hi;
    logic        req_ok;
    logic        hit;
    logic [2:0]  k_d;
    logic [63:0] data_d;
    logic [31:0] half;
    logic        valid;
    logic [63:0] chain [STAGES_PER_CYCLE+1];

    always_comb begin
        opnd    = {bus.op_b_i, bus.op_a_i} & {64{LOGIC_GATING ? bus.ascon_inv_en_i : 1'b1}};
        req_sig = ascon_inv_sigma_idx(bus.ascon_inv_op_i);
        req_hi  = ascon_inv_is_high(bus.ascon_inv_op_i);
        req_ok  = ascon_inv_op_valid(bus.ascon_inv_op_i);
        hit     = RESULT_CACHE && cache_vld_q && cache_opnd_q == opnd && cache_sig_q == req_sig;
        k_d     = k_q + STEP;
        data_d  = chain[STAGES_PER_CYCLE];
        half    = hi_q ? data_q[63:32] : data_q[31:0];
        valid   = state_q == DONE && !bus.flush_i;
    end

    assign chain[0] = data_q;

    for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_stage
        ascon_inv_stage u_stage (
            .data_i (chain[j]),
            .sig_i  (sig_q),
            .k_i    (k_q + 3'(j)),
            .data_o (chain[j+1])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_q       <= '0;
            opnd_q       <= '0;
            sig_q        <= '0;
            k_q          <= '0;
            hi_q         <= 1'b0;
            bad_q        <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_opnd_q <= '0;
            cache_sig_q  <= '0;
            cache_res_q  <= '0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.ascon_inv_en_i) begin
                    hi_q    <= req_hi;
                    bad_q   <= !req_ok;
                    opnd_q  <= opnd;
                    sig_q   <= req_sig;
                    k_q     <= '0;
                    data_q  <= !req_ok ? '0 : hit ? cache_res_q : opnd;
                    state_q <= (!req_ok || hit) ? DONE : CALC;
                end
                CALC: begin
                    data_q  <= data_d;
                    k_q     <= k_d;
                    state_q <= k_d == LAST ? DONE : CALC;
                end
                DONE: begin
                    // Undefined ops leave the cache alone so a pending paired op still hits.
                    if (RESULT_CACHE && !bad_q) begin
                        cache_vld_q  <= 1'b1;
                        cache_opnd_q <= opnd_q;
                        cache_sig_q  <= sig_q;
                        cache_res_q  <= data_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ascon_inv_valid_o  = valid;
    assign bus.ascon_inv_busy_o   = state_q != IDLE;
    assign bus.ascon_inv_result_o = (LOGIC_GATING && !valid) ? '0 : half;

endmodule

// File: tb/tb_ascon_inv_unit.sv
// tb_ascon_inv_unit: table vectors plus hand-written corner sequences across five configurations,
// checked against a forward-sigma golden model through an expected-result queue.
module tb_ascon_inv_unit;
    import ascon_inv_unit_pkg::*;

    typedef struct {
        int            d;
        ascon_inv_op_t op;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   ex;
        int            lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    en;
    ascon_inv_op_t op_s;
    logic [31:0]   a_s;
    logic [31:0]   b_s;
    logic          flush;
    logic [31:0]   res [5];
    logic [4:0]    vld;
    logic [4:0]    busy;

    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];
    vec_t tbl [$];

    always #5 clk = ~clk;

    // Duts 0..3: S=1,2,3,6 with cache and gating; dut 4: S=1, no cache, no gating.
    for (genvar d = 0; d < 5; d++) begin : g_dut
        localparam int S = d == 1 ? 2 : d == 2 ? 3 : d == 3 ? 6 : 1;
        localparam bit OPT = d != 4;
        ascon_inv_unit_if bus_if ();
        assign bus_if.ascon_inv_en_i = en[d];
        assign bus_if.ascon_inv_op_i = op_s;
        assign bus_if.op_a_i         = a_s;
        assign bus_if.op_b_i         = b_s;
        assign bus_if.flush_i        = flush;
        assign res[d]  = bus_if.ascon_inv_result_o;
        assign vld[d]  = bus_if.ascon_inv_valid_o;
        assign busy[d] = bus_if.ascon_inv_busy_o;
        ascon_inv_unit #(
            .LOGIC_GATING     (OPT),
            .STAGES_PER_CYCLE (S),
            .RESULT_CACHE     (OPT)
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus_if)
        );
    end

    function automatic logic [63:0] rotr(logic [63:0] x, int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    function automatic logic [63:0] fwd(logic [63:0] x, int i);
        return x ^ rotr(x, RA[i]) ^ rotr(x, RB[i]);
    endfunction

    function automatic ascon_inv_op_t mkop(int i, bit low);
        return ascon_inv_op_t'(4'(2 * i + int'(low)));
    endfunction

    function automatic int miss_lat(int d);
        return d == 1 ? 4 : d == 2 ? 3 : d == 3 ? 2 : 7;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", n, act, want);
        end
    endtask

    task automatic run(input int d, input ascon_inv_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ex, input int lat, input bit tog);
        exp_t e;
        int   cyc;
        bit   got;
        bit   nz;
        @(negedge clk);
        op_s  = op;
        a_s   = a;
        b_s   = b;
        en[d] = 1'b1;
        sb.push_back('{ex, lat});
        got = 0;
        nz  = 0;
        cyc = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(posedge clk);
            #1;
            if (vld[d]) begin
                got = 1;
                cyc = c;
            end else begin
                if (d != 4 && res[d] != 0) nz = 1;
                if (tog) begin
                    @(negedge clk);
                    en[d] = ~en[d];
                end
            end
        end
        e = sb.pop_front();
        chk($sformatf("valid_seen d%0d op%0d", d, op), 64'(got), 64'd1);
        if (got) begin
            chk($sformatf("result d%0d op%0d", d, op), 64'(res[d]), 64'(e.res));
            chk($sformatf("latency d%0d op%0d", d, op), 64'(cyc), 64'(e.lat));
        end
        chk($sformatf("gated_zero d%0d", d), 64'(nz), 64'd0);
        @(negedge clk);
        en[d] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("single_pulse d%0d", d), 64'(vld[d]), 64'd0);
    endtask

    initial begin
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] z;
        bit          sawv;
        rst   = 1'b1;
        en    = '0;
        flush = 1'b0;
        op_s  = ASCINV0H;
        a_s   = '0;
        b_s   = '0;

        tbl.push_back('{0, ASCINV0L, 32'h0000_0001, 32'h0000_2010, 32'h0000_0001, 7});
        tbl.push_back('{0, ASCINV0H, 32'h0000_0001, 32'h0000_2010, 32'h0000_0000, 1});
        tbl.push_back('{4, ASCINV2H, 32'h0000_0001, 32'h8400_0000, 32'h0000_0000, 7});
        tbl.push_back('{4, ASCINV2L, 32'h0000_0001, 32'h8400_0000, 32'h0000_0001, 7});
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 5; i++) begin
                tbl.push_back('{d, mkop(i, 0), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, miss_lat(d)});
                tbl.push_back('{d, mkop(i, 1), 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, miss_lat(d)});
            end
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("reset_busy d%0d", d), 64'(busy[d]), 64'd0);
            chk($sformatf("reset_valid d%0d", d), 64'(vld[d]), 64'd0);
            chk($sformatf("reset_result d%0d", d), 64'(res[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[n]) run(tbl[n].d, tbl[n].op, tbl[n].a, tbl[n].b, tbl[n].ex, tbl[n].lat, 1'b0);

        // Undefined op completes immediately with zero and leaves the cache intact.
        run(0, ASCINV0L, 32'h0000_0001, 32'h0000_2010, 32'h0000_0001, 7, 1'b0);
        run(0, ascon_inv_op_t'(4'hC), 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, 1'b0);
        run(0, ASCINV0H, 32'h0000_0001, 32'h0000_2010, 32'h0000_0000, 1, 1'b0);

        // Without gating the result port keeps showing the data half after valid.
        run(4, ASCINV2L, 32'h0000_0001, 32'h8400_0000, 32'h0000_0001, 7, 1'b0);
        chk("ungated_hold", 64'(res[4]), 64'd1);

        // Flush at cycle 3 aborts with no valid and no cache write.
        x = 64'h0123_4567_89AB_CDEF;
        y = fwd(x, 1);
        sawv = 0;
        @(negedge clk);
        op_s  = ASCINV1H;
        a_s   = y[31:0];
        b_s   = y[63:32];
        en[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) sawv = 1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        if (vld[0]) sawv = 1;
        chk("flush_busy", 64'(busy[0]), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        en[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (vld[0]) sawv = 1;
        end
        chk("flush_no_valid", 64'(sawv), 64'd0);
        run(0, ASCINV1H, y[31:0], y[63:32], x[63:32], 7, 1'b0);

        // Reset mid-CALC zeroes outputs and invalidates the cache.
        x = 64'hDEAD_BEEF_0BAD_F00D;
        y = fwd(x, 3);
        run(0, ASCINV3L, y[31:0], y[63:32], x[31:0], 7, 1'b0);
        z = fwd(64'h5555_0000_AAAA_FFFF, 4);
        @(negedge clk);
        op_s  = ASCINV4H;
        a_s   = z[31:0];
        b_s   = z[63:32];
        en[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        en[0] = 1'b0;
        #1;
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_valid", 64'(vld[0]), 64'd0);
        chk("rst_result", 64'(res[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(0, ASCINV3H, y[31:0], y[63:32], x[63:32], 7, 1'b0);

        // Random round trips: fast config for bulk, S=1 with en toggling during CALC.
        for (int i = 0; i < 5; i++) begin
            for (int n = 0; n < 1000; n++) begin
                x = {$urandom, $urandom};
                y = fwd(x, i);
                run(3, mkop(i, 0), y[31:0], y[63:32], x[63:32], 2, 1'b0);
                run(3, mkop(i, 1), y[31:0], y[63:32], x[31:0], 1, 1'b0);
            end
            for (int n = 0; n < 4; n++) begin
                x = {$urandom, $urandom};
                y = fwd(x, i);
                run(0, mkop(i, 0), y[31:0], y[63:32], x[63:32], 7, 1'b1);
                run(0, mkop(i, 1), y[31:0], y[63:32], x[31:0], 1, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
